// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel tick, h/v counters, hsync/vsync and blanked colour for 640x480@60
// Optional VGA_SYNC_ALIGN_EN: hsync/vsync/video_on delayed one pixel to line up with rgb_out.
module vga_timing_gen #(
   parameter int       CLK_DIV  = 4,
   parameter int       H_ACTIVE = 640,
   parameter int       H_FP     = 16,
   parameter int       H_SYNC   = 96,
   parameter int       H_BP     = 48,
   parameter int       V_ACTIVE = 480,
   parameter int       V_FP     = 10,
   parameter int       V_SYNC   = 2,
   parameter int       V_BP     = 33,
   parameter logic     SYNC_POL = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rgb_in,
   output logic [10:0] xCoord,
   output logic [10:0] yCoord,
   output logic        hsync,
   output logic        vsync,
   output logic        video_on,
   output logic        pix_tick,
   output logic        frame_start,
   output logic [7:0]  rgb_out
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = $clog2(CLK_DIV);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [10:0] X_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] Y_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] X_ACT    = 11'(H_ACTIVE);
   localparam logic [10:0] Y_ACT    = 11'(V_ACTIVE);
   localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [DIV_W-1:0] r_div_cnt;
   logic [10:0]      r_x;
   logic [10:0]      r_y;
   logic [10:0]      w_x_nxt;
   logic [10:0]      w_y_nxt;
   logic             r_hsync;
   logic             r_vsync;
   logic [7:0]       r_rgb;
   logic             w_pix_tick;
   logic             w_x_wrap;
   logic             w_video_on;

   assign w_pix_tick = (r_div_cnt == DIV_LAST);
   assign w_x_wrap   = (r_x == X_LAST);
   assign w_video_on = (r_x < X_ACT) && (r_y < Y_ACT);

   always_comb begin
      w_x_nxt = r_x + 11'd1;
      w_y_nxt = r_y;
      if (w_x_wrap) begin
         w_x_nxt = '0;
         w_y_nxt = (r_y == Y_LAST) ? 11'd0 : r_y + 11'd1;
      end
   end

   // Syncs decode the next counter values so they stay aligned with xCoord/yCoord.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div_cnt <= '0;
         r_x       <= '0;
         r_y       <= '0;
         r_hsync   <= ~SYNC_POL;
         r_vsync   <= ~SYNC_POL;
         r_rgb     <= '0;
      end else begin
         r_div_cnt <= w_pix_tick ? '0 : r_div_cnt + DIV_W'(1);
         if (w_pix_tick) begin
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_hsync <= (w_x_nxt >= HS_FIRST && w_x_nxt <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
            r_vsync <= (w_y_nxt >= VS_FIRST && w_y_nxt <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
            r_rgb   <= w_video_on ? rgb_in : 8'h00;
         end
      end
   end

`ifdef VGA_SYNC_ALIGN_EN
   logic r_hsync_d;
   logic r_vsync_d;
   logic r_video_on_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hsync_d    <= ~SYNC_POL;
         r_vsync_d    <= ~SYNC_POL;
         r_video_on_d <= 1'b0;
      end else if (w_pix_tick) begin
         r_hsync_d    <= r_hsync;
         r_vsync_d    <= r_vsync;
         r_video_on_d <= w_video_on;
      end
   end

   assign hsync    = r_hsync_d;
   assign vsync    = r_vsync_d;
   assign video_on = r_video_on_d;
`else
   assign hsync    = r_hsync;
   assign vsync    = r_vsync;
   assign video_on = w_video_on;
`endif

   assign xCoord      = r_x;
   assign yCoord      = r_y;
   assign pix_tick    = w_pix_tick;
   assign frame_start = w_pix_tick && w_x_wrap && (r_y == Y_LAST);
   assign rgb_out     = r_rgb;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench with colour scoreboard for vga_timing_gen
module tb_vga_timing_gen;

   localparam int   DIV = 4;
   localparam logic POL = 1'b0;

   typedef struct packed { int ha, hf, hs, hb, va, vf, vs, vb; } cfg_t;
   typedef struct packed { logic [10:0] x, y; logic hs, vs, von, von_raw, tick, fs; } exp_t;

   localparam cfg_t CFG_S = '{ha: 16, hf: 4, hs: 6, hb: 6, va: 12, vf: 2, vs: 2, vb: 3};
   localparam cfg_t CFG_D = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33};
   localparam int   FRAME_CLKS = 32 * 19 * DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rgb_in = 8'h00;

   logic [10:0] xCoord, yCoord, d_x, d_y;
   logic        hsync, vsync, video_on, pix_tick, frame_start;
   logic        d_hs, d_vs, d_von, d_tick, d_fs;
   logic [7:0]  rgb_out, d_rgb;

   int          c = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          fs_seen = 0;
   int          ff_cnt = 0;
   bit          hold_ff = 1'b0;
   logic [7:0]  m_rgb = 8'h00;
   logic [7:0]  sb[$];

   always #5 clk = ~clk;

   vga_timing_gen #(
      .CLK_DIV(DIV), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
      .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(POL)
   ) u_dut (
      .clk(clk), .rst(rst), .rgb_in(rgb_in), .xCoord(xCoord), .yCoord(yCoord),
      .hsync(hsync), .vsync(vsync), .video_on(video_on), .pix_tick(pix_tick),
      .frame_start(frame_start), .rgb_out(rgb_out)
   );

   vga_timing_gen u_dut_def (
      .clk(clk), .rst(rst), .rgb_in(rgb_in), .xCoord(d_x), .yCoord(d_y),
      .hsync(d_hs), .vsync(d_vs), .video_on(d_von), .pix_tick(d_tick),
      .frame_start(d_fs), .rgb_out(d_rgb)
   );

   // Reference: position is the number of whole pixel periods since the last reset edge.
   function automatic exp_t model(cfg_t g, int cc);
      exp_t e;
      int ht, vt, n, p, q;
      ht = g.ha + g.hf + g.hs + g.hb;
      vt = g.va + g.vf + g.vs + g.vb;
      n  = cc / DIV;
      p  = n % (ht * vt);
      e  = '0;
      e.x       = 11'(p % ht);
      e.y       = 11'(p / ht);
      e.tick    = (cc % DIV) == DIV - 1;
      e.fs      = e.tick && (p == ht * vt - 1);
      e.von_raw = (p % ht < g.ha) && (p / ht < g.va);
      q = p;
`ifdef VGA_SYNC_ALIGN_EN
      if (n == 0) begin
         e.hs  = ~POL;
         e.vs  = ~POL;
         e.von = 1'b0;
         return e;
      end
      q = (n - 1) % (ht * vt);
`endif
      e.hs  = (q % ht >= g.ha + g.hf && q % ht < g.ha + g.hf + g.hs) ? POL : ~POL;
      e.vs  = (q / ht >= g.va + g.vf && q / ht < g.va + g.vf + g.vs) ? POL : ~POL;
      e.von = (q % ht < g.ha) && (q / ht < g.va);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (clk %0d)", tag, obs, exp, c);
      end
   endtask

   task automatic check_now();
      exp_t e, d;
      e = model(CFG_S, c);
      d = model(CFG_D, c);
      chk("x", xCoord, e.x);
      chk("y", yCoord, e.y);
      chk("hsync", hsync, e.hs);
      chk("vsync", vsync, e.vs);
      chk("video_on", video_on, e.von);
      chk("pix_tick", pix_tick, e.tick);
      chk("frame_start", frame_start, e.fs);
      chk("def_x", d_x, d.x);
      chk("def_y", d_y, d.y);
      chk("def_hsync", d_hs, d.hs);
      chk("def_vsync", d_vs, d.vs);
      chk("def_frame_start", d_fs, d.fs);
      if (frame_start) fs_seen++;
      if (e.tick) begin
         rgb_in = hold_ff ? 8'hFF : 8'($urandom);
         sb.push_back(e.von_raw ? rgb_in : 8'h00);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         check_now();
         @(posedge clk);
         c++;
         @(negedge clk);
         if (sb.size() > 0) begin
            m_rgb = sb.pop_front();
            chk("rgb_out", rgb_out, m_rgb);
            if (rgb_out === 8'hFF) ff_cnt++;
         end else begin
            chk("rgb_hold", rgb_out, m_rgb);
         end
      end
   endtask

   task automatic do_reset(input int k);
      rst = 1'b1;
      for (int i = 0; i < k; i++) begin
         @(posedge clk);
         c = 0;
         @(negedge clk);
         chk("rst_pix_tick", pix_tick, 1'b0);
         chk("rst_x", xCoord, 11'd0);
         chk("rst_y", yCoord, 11'd0);
         chk("rst_rgb", rgb_out, 8'h00);
      end
      sb.delete();
      m_rgb   = 8'h00;
      fs_seen = 0;
      rst     = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      c   = 0;

      run(40);
      chk("cadence_x", xCoord, 11'd10);

      run(680);
      chk("pre_reset_x", xCoord, 11'd20);
      chk("pre_reset_y", yCoord, 11'd5);
      do_reset(3);

      run(2 * FRAME_CLKS + 40);
      chk("frame_start_count", fs_seen, 2);

      hold_ff = 1'b1;
      ff_cnt  = 0;
      run(FRAME_CLKS);
      chk("active_ff_count", ff_cnt, 16 * 12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
